weight_bram_reader: RTL and testbench

//  Read-side sequencer for one neuron's 16-bit weight BRAM (negedge-read, 28-deep, 5-bit address).

---
 rtl/ann_pkg.sv | 16 +
 rtl/wbr_skid_fifo.sv | 79 +++++++
 rtl/weight_bram_reader.sv | 188 ++++++++++++++++++
 tb/tb_weight_bram_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared constants for the neuron weight path: word/address widths, BRAM
// depth, and the state encoding of the weight read sequencer.
package ann_pkg;

  localparam int ANN_DATA_W = 16;
  localparam int ANN_ADDR_W = 5;
  localparam int ANN_WDEPTH = 28;

  typedef logic [1:0] wbr_state_t;

  localparam wbr_state_t S_IDLE  = 2'd0;
  localparam wbr_state_t S_FETCH = 2'd1;
  localparam wbr_state_t S_DRAIN = 2'd2;
  localparam wbr_state_t S_DONE  = 2'd3;

endpackage

// File: rtl/wbr_skid_fifo.sv
// Two-entry skid FIFO between the BRAM capture point and the MAC consumer.
// The head entry drives the output directly, so dout is a plain flop.
// A simultaneous push and pop on a full FIFO keeps the count at 2.
module wbr_skid_fifo #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop, do_push;

  // Storage and occupancy registers; clr wipes contents so dout reads 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Shift/fill logic keyed on current occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    case (cnt_q)
      2'd0: begin
        if (do_push) begin
          head_d = din;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (do_push && do_pop) begin
          head_d = din;
        end else if (do_push) begin
          tail_d = din;
          cnt_d  = 2'd2;
        end else if (do_pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) begin
            tail_d = din;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  assign dout  = head_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/weight_bram_reader.sv
// Read-side sequencer for one neuron's weight BRAM. On START it reads
// BASE..BASE+COUNT-1 (BRAM samples on the falling edge, data captured on the
// next rising edge) and streams the words out through a 2-entry skid FIFO.
// Optional feature macro: WBR_CHECKSUM_EN adds CSUM, the modulo-2^16 sum of
// the words accepted in the current burst.
//
// state   | meaning
// S_IDLE  | waiting for START
// S_FETCH | issuing reads while there is room downstream
// S_DRAIN | all reads issued, waiting for the last word to be accepted
// S_DONE  | one-cycle DONE pulse
//
// Zero-length and out-of-range requests are run as empty bursts through
// FETCH/DRAIN so that DONE timing does not depend on the request.
module weight_bram_reader
  import ann_pkg::*;
#(
  parameter int DATA_W = ANN_DATA_W,
  parameter int ADDR_W = ANN_ADDR_W,
  parameter int DEPTH  = ANN_WDEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   COUNT,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_IDX,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
`ifdef WBR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] CSUM
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;

  wbr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              en_q, en_d;
  logic              err_q, err_d;
`ifdef WBR_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic [SUM_W-1:0]         span;
  logic                     bad_req;
  logic                     start_acc;
  logic                     fifo_pop;
  logic                     fifo_full, fifo_empty;
  logic [1:0]               fifo_cnt;
  logic [1:0]               occ_next;
  logic                     issue_ok;
  logic [DATA_W+ADDR_W-1:0] fifo_din, fifo_dout;

  assign span      = SUM_W'(BASE) + SUM_W'(COUNT);
  assign bad_req   = (span > SUM_W'(DEPTH));
  assign start_acc = (state_q == S_IDLE) && START;

  // en_q marks the single read in flight; its data lands in the FIFO this edge.
  assign fifo_din = {addr_q - base_q, BRAM_DO};
  assign fifo_pop = W_VALID && W_READY;
  // Occupancy once this cycle's capture and pop settle; a new read may only
  // be issued if that leaves a free slot for its own capture next cycle.
  assign occ_next = fifo_cnt + {1'b0, en_q} - {1'b0, fifo_pop};
  assign issue_ok = (occ_next < 2'd2) && !(fifo_full && !fifo_pop);

  wbr_skid_fifo #(.W(DATA_W + ADDR_W)) u_fifo (
    .clk   (CLK),
    .clr   (RST || start_acc),
    .push  (en_q),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // State and sequencing registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef WBR_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      en_q     <= en_d;
      err_q    <= err_d;
`ifdef WBR_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Next-state and read-issue logic.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    count_d  = count_q;
    issued_d = issued_q;
    en_d     = 1'b0;
    err_d    = err_q;
`ifdef WBR_CHECKSUM_EN
    csum_d   = fifo_pop ? (csum_q + W_DATA) : csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_FETCH;
          base_d   = BASE;
          err_d    = bad_req;
          count_d  = bad_req ? '0 : COUNT;
          issued_d = '0;
`ifdef WBR_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      S_FETCH: begin
        if (issued_q == count_q) begin
          state_d = S_DRAIN;
        end else if (issue_ok) begin
          en_d     = 1'b1;
          addr_d   = base_q + issued_q[ADDR_W-1:0];
          issued_d = issued_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!en_q && (fifo_empty || ((fifo_cnt == 2'd1) && fifo_pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore status outputs.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_q)
      S_FETCH, S_DRAIN: BUSY = 1'b1;
      S_DONE:           DONE = 1'b1;
      default: begin
        BUSY = 1'b0;
        DONE = 1'b0;
      end
    endcase
  end

  assign BRAM_ADDR = addr_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = 1'b0;
  assign ERR       = err_q;
  assign W_DATA    = fifo_dout[DATA_W-1:0];
  assign W_IDX     = fifo_dout[DATA_W +: ADDR_W];
  assign W_VALID   = !fifo_empty;
`ifdef WBR_CHECKSUM_EN
  assign CSUM      = csum_q;
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Directed bench for weight_bram_reader with a behavioural negedge-read BRAM
// holding mem[i] = 16'h0100 + i. Latencies are counted in rising edges from
// the edge that accepts START.
module tb_weight_bram_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [4:0]  BASE;
  logic [5:0]  COUNT;
  logic [4:0]  BRAM_ADDR;
  logic        BRAM_EN;
  logic        BRAM_WE;
  logic [15:0] BRAM_DO;
  logic [15:0] W_DATA;
  logic [4:0]  W_IDX;
  logic        W_VALID;
  logic        W_READY;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
`ifdef WBR_CHECKSUM_EN
  logic [15:0] CSUM;
`endif

  weight_bram_reader dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BASE      (BASE),
    .COUNT     (COUNT),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DO   (BRAM_DO),
    .W_DATA    (W_DATA),
    .W_IDX     (W_IDX),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
`ifdef WBR_CHECKSUM_EN
    ,
    .CSUM      (CSUM)
`endif
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:27];

  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
  end

  int          cyc = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;
  int          we_bad = 0;
  int          done_cyc = 0;
  int          vrise_cyc = 0;
  logic        v_prev = 1'b0;
  logic [20:0] got_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (BRAM_WE !== 1'b0) we_bad <= we_bad + 1;
    if (BRAM_EN === 1'b1) en_cnt <= en_cnt + 1;
    if (DONE === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (W_VALID === 1'b1 && !v_prev) vrise_cyc <= cyc;
    v_prev <= W_VALID;
    if (W_VALID === 1'b1 && W_READY && !RST) got_q.push_back({W_IDX, W_DATA});
  end

  int n_pass = 0;
  int n_total = 0;
  int w0 = 0;
  int e0 = 0;
  int start_edge = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"},  32'(BRAM_ADDR), 32'd0);
    chk({tag, "_en"},    32'(BRAM_EN),   32'd0);
    chk({tag, "_wdata"}, 32'(W_DATA),    32'd0);
    chk({tag, "_widx"},  32'(W_IDX),     32'd0);
    chk({tag, "_valid"}, 32'(W_VALID),   32'd0);
    chk({tag, "_busy"},  32'(BUSY),      32'd0);
    chk({tag, "_done"},  32'(DONE),      32'd0);
    chk({tag, "_err"},   32'(ERR),       32'd0);
  endtask

  task automatic do_burst(input logic [4:0] b, input logic [5:0] c,
                          input bit toggle, input bit inject);
    int d0;
    w0 = got_q.size();
    e0 = en_cnt;
    d0 = done_cnt;
    W_READY = 1'b1;
    START = 1'b1;
    BASE = b;
    COUNT = c;
    start_edge = cyc + 1;
    step();
    START = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      if (toggle) W_READY = ~W_READY;
      if (inject && i == 2) begin
        START = 1'b1;
        BASE = 5'd0;
        COUNT = 6'd5;
      end else begin
        START = 1'b0;
      end
      step();
    end
    START = 1'b0;
    W_READY = 1'b1;
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic chk_words(input string tag, input int b, input int n);
    logic [31:0] exp_w;
    chk({tag, "_nwords"}, 32'(got_q.size() - w0), 32'(n));
    for (int i = 0; i < n && (w0 + i) < got_q.size(); i++) begin
      exp_w = {11'd0, 5'(i), 16'(16'h0100 + b + i)};
      chk({tag, "_word"}, {11'd0, got_q[w0 + i]}, exp_w);
    end
  endtask

  initial begin
    for (int i = 0; i < 28; i++) mem[i] = 16'h0100 + 16'(i);
    RST = 1'b1;
    START = 1'b0;
    BASE = '0;
    COUNT = '0;
    W_READY = 1'b1;
    repeat (3) step();
    chk_idle("reset");
    RST = 1'b0;
    step();

    // Full burst at one word per cycle.
    do_burst(5'd0, 6'd28, 1'b0, 1'b0);
    chk("full_done_lat",  32'(done_cyc - start_edge),  32'd30);
    chk("full_first_lat", 32'(vrise_cyc - start_edge), 32'd2);
    chk("full_reads",     32'(en_cnt - e0),            32'd28);
    chk("full_err",       32'(ERR),                    32'd0);
    chk("full_busy_end",  32'(BUSY),                   32'd0);
    chk_words("full", 0, 28);

    // Backpressure with READY toggling 1,0,1,0...
    do_burst(5'd4, 6'd6, 1'b1, 1'b0);
    chk("bp_reads", 32'(en_cnt - e0), 32'd6);
    chk_words("bp", 4, 6);

    // Zero-length request.
    do_burst(5'd7, 6'd0, 1'b0, 1'b0);
    chk("zero_done_lat", 32'(done_cyc - start_edge), 32'd2);
    chk("zero_reads",    32'(en_cnt - e0),           32'd0);
    chk("zero_words",    32'(got_q.size() - w0),     32'd0);
    chk("zero_err",      32'(ERR),                   32'd0);

    // Out-of-range request: 20 + 9 > 28.
    do_burst(5'd20, 6'd9, 1'b0, 1'b0);
    chk("oor_done_lat", 32'(done_cyc - start_edge), 32'd2);
    chk("oor_reads",    32'(en_cnt - e0),           32'd0);
    chk("oor_err",      32'(ERR),                   32'd1);

    // Second START while busy is ignored; the accepted START also clears ERR.
    do_burst(5'd10, 6'd3, 1'b0, 1'b1);
    chk("busy_err_clr", 32'(ERR), 32'd0);
    chk_words("busy", 10, 3);
    repeat (10) step();
    chk("busy_reads", 32'(en_cnt - e0),       32'd3);
    chk("busy_nodup", 32'(got_q.size() - w0), 32'd3);

    // Burst ending exactly at the top address: 24 + 4 == 28 is legal.
    do_burst(5'd24, 6'd4, 1'b0, 1'b0);
    chk("top_err", 32'(ERR), 32'd0);
    chk_words("top", 24, 4);

    // Reset in the middle of a burst.
    w0 = got_q.size();
    START = 1'b1;
    BASE = 5'd0;
    COUNT = 6'd10;
    step();
    START = 1'b0;
    for (int i = 0; i < 100 && (got_q.size() - w0) < 3; i++) step();
    chk("rst_reach3", 32'((got_q.size() - w0) >= 3), 32'd1);
    chk("rst_busy",   32'(BUSY), 32'd1);
    RST = 1'b1;
    step();
    chk_idle("rst_mid");
    RST = 1'b0;
    step();
    do_burst(5'd2, 6'd2, 1'b0, 1'b0);
    chk_words("after_rst", 2, 2);

`ifdef WBR_CHECKSUM_EN
    do_burst(5'd0, 6'd4, 1'b0, 1'b0);
    chk("csum", 32'(CSUM), 32'h0406);
`endif

    step();
    chk("we_never", 32'(we_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
